// File: rtl/apb_uart_stream_bridge.sv
// APB master that drives a 16750-style UART from byte streams: programs the
// UART after reset, then polls LSR and moves bytes between the streams and
// the UART's THR/RBR registers.

package apb_uart_stream_bridge_pkg;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_resp_t;

endpackage

// state      | meaning
// -----------+----------------------------------------------------------
// ST_INIT    | issuing the six configuration writes (index init_idx_q)
// ST_SERVICE | per completed transfer pick RBR read, THR write or LSR poll
//
// The APB phase (idle / SETUP / ACCESS) is carried by psel_q/penable_q.
module apb_uart_stream_bridge #(
  parameter type             apb_req_t  = apb_uart_stream_bridge_pkg::apb_req_t,
  parameter type             apb_resp_t = apb_uart_stream_bridge_pkg::apb_resp_t,
  parameter logic [31:0]     BaseAddr   = 32'h0,
  parameter logic [15:0]     ClkDiv     = 16'd27,
  parameter logic [7:0]      LcrVal     = 8'h03,
  parameter logic [7:0]      FcrVal     = 8'h07,
  parameter int unsigned     TxBurst    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output apb_req_t   apb_req_o,
  input  apb_resp_t  apb_rsp_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       init_done_o,
  output logic       err_o
);

  localparam int unsigned     CW        = $clog2(TxBurst + 1);
  localparam logic [CW-1:0]   BurstVal  = CW'(TxBurst);
  localparam logic [CW-1:0]   CreditOne = CW'(1);

  localparam logic [2:0] RegRbrThr = 3'd0;
  localparam logic [2:0] RegDll    = 3'd0;
  localparam logic [2:0] RegDlm    = 3'd1;
  localparam logic [2:0] RegIer    = 3'd1;
  localparam logic [2:0] RegFcr    = 3'd2;
  localparam logic [2:0] RegLcr    = 3'd3;
  localparam logic [2:0] RegLsr    = 3'd5;
  localparam logic [2:0] InitLast  = 3'd5;

  typedef enum logic {ST_INIT, ST_SERVICE} state_e;
  typedef enum logic [1:0] {OP_INIT_WR, OP_LSR_RD, OP_RBR_RD, OP_THR_WR} op_e;

  function automatic logic [31:0] reg_addr(input logic [2:0] idx);
    return BaseAddr + {27'd0, idx, 2'b00};
  endfunction

  // Init order: open divisor latch, divisor low/high, final LCR, FCR, IER.
  function automatic logic [2:0] init_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    return RegLcr;
      3'd1:    return RegDll;
      3'd2:    return RegDlm;
      3'd3:    return RegLcr;
      3'd4:    return RegFcr;
      default: return RegIer;
    endcase
  endfunction

  function automatic logic [7:0] init_val(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h80;
      3'd1:    return ClkDiv[7:0];
      3'd2:    return ClkDiv[15:8];
      3'd3:    return LcrVal;
      3'd4:    return FcrVal;
      default: return 8'h00;
    endcase
  endfunction

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          tx_ready_q, tx_ready_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          dr_q, dr_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          init_done_q, init_done_d;
  logic          err_q, err_d;
  logic          issue;

  logic          unused_prdata;
  assign unused_prdata = ^apb_rsp_i.prdata[31:8];

  // State and registered APB/stream outputs; reset abandons any transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      op_q        <= OP_INIT_WR;
      init_idx_q  <= 3'd0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      tx_ready_q  <= 1'b0;
      credit_q    <= '0;
      dr_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      init_idx_q  <= init_idx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      tx_ready_q  <= tx_ready_d;
      credit_q    <= credit_d;
      dr_q        <= dr_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  // Advance the APB phase, absorb a completed transfer, then choose the next one.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    init_idx_d  = init_idx_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    tx_ready_d  = 1'b0;
    credit_d    = credit_q;
    dr_d        = dr_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    issue       = 1'b0;

    // Consume first so that a byte landing in the same cycle replaces it.
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    if (!psel_q) begin
      issue = 1'b1;
    end else if (!penable_q) begin
      penable_d = 1'b1;
    end else if (apb_rsp_i.pready) begin
      issue = 1'b1;
      if (apb_rsp_i.pslverr) begin
        err_d = 1'b1;
      end
      case (op_q)
        OP_INIT_WR: begin
          if (init_idx_q == InitLast) begin
            state_d     = ST_SERVICE;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
          end
        end
        OP_LSR_RD: begin
          if (apb_rsp_i.pslverr) begin
            dr_d = 1'b0;
          end else begin
            dr_d = apb_rsp_i.prdata[0];
            // THRE=0 keeps the credit: the FIFO can only have drained since.
            if (apb_rsp_i.prdata[5]) begin
              credit_d = BurstVal;
            end
          end
        end
        OP_RBR_RD: begin
          dr_d = 1'b0;
          if (!apb_rsp_i.pslverr) begin
            rx_valid_d = 1'b1;
            rx_data_d  = apb_rsp_i.prdata[7:0];
          end
        end
        OP_THR_WR: begin
          if (credit_q != '0) begin
            credit_d = credit_q - CreditOne;
          end
        end
        default: ;
      endcase
    end

    if (issue) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwdata_d  = '0;
      if (state_d == ST_INIT) begin
        op_d     = OP_INIT_WR;
        pwrite_d = 1'b1;
        paddr_d  = reg_addr(init_reg(init_idx_d));
        pwdata_d = {24'd0, init_val(init_idx_d)};
      end else if (dr_d && !rx_valid_d) begin
        op_d     = OP_RBR_RD;
        pwrite_d = 1'b0;
        paddr_d  = reg_addr(RegRbrThr);
      end else if ((credit_d != '0) && tx_valid_i) begin
        op_d       = OP_THR_WR;
        pwrite_d   = 1'b1;
        paddr_d    = reg_addr(RegRbrThr);
        pwdata_d   = {24'd0, tx_data_i};
        tx_ready_d = 1'b1;
      end else begin
        op_d     = OP_LSR_RD;
        pwrite_d = 1'b0;
        paddr_d  = reg_addr(RegLsr);
      end
    end
  end

  // Pack the registered request fields into the bus struct.
  always_comb begin
    apb_req_o         = '0;
    apb_req_o.psel    = psel_q;
    apb_req_o.penable = penable_q;
    apb_req_o.pwrite  = pwrite_q;
    apb_req_o.paddr   = paddr_q;
    apb_req_o.pwdata  = pwdata_q;
  end

  assign tx_ready_o  = tx_ready_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_apb_uart_stream_bridge.sv
// Bench for apb_uart_stream_bridge: a small UART-like APB slave, a tx byte
// feeder, and a scoreboard of expected non-poll transfers.
module tb_apb_uart_stream_bridge;
  import apb_uart_stream_bridge_pkg::*;

  localparam logic [15:0] CLK_DIV = 16'h1234;
  localparam logic [31:0] A_LSR   = 32'h14;
  localparam logic [31:0] A_DATA  = 32'h00;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic [7:0] rbr_in;
    logic [7:0] exp_rx_data;
  } rx_vec_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  apb_req_t  req;
  apb_resp_t rsp;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       init_done;
  logic       err;

  apb_uart_stream_bridge #(
    .apb_req_t (apb_req_t),
    .apb_resp_t(apb_resp_t),
    .BaseAddr  (32'h0),
    .ClkDiv    (CLK_DIV),
    .LcrVal    (8'h03),
    .FcrVal    (8'h07),
    .TxBurst   (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .apb_req_o  (req),
    .apb_rsp_i  (rsp),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .init_done_o(init_done),
    .err_o      (err)
  );

  // ---------------- UART-like slave ----------------
  logic       thre = 1'b1;
  logic [7:0] rx_bytes [0:63];
  int         rx_wr = 0;
  int         rx_rd = 0;
  int         wait_req = 0;
  int         wait_used = 0;
  int         err_req = 0;
  int         err_used = 0;
  logic [7:0] err_byte = 8'h00;
  int         wait_left = 0;
  logic       slv_dr;

  assign slv_dr = (rx_wr != rx_rd);

  always_comb begin
    rsp = '0;
    rsp.pready = (wait_left == 0);
    if (!req.pwrite && req.paddr == A_LSR)
      rsp.prdata = {24'h0, 1'b0, thre, thre, 4'h0, slv_dr};
    else if (!req.pwrite && req.paddr == A_DATA)
      rsp.prdata = {24'h0, rx_bytes[rx_rd[5:0]]};
    rsp.pslverr = (err_req != err_used) && req.psel && req.penable && req.pwrite &&
                  req.paddr == A_DATA && req.pwdata[7:0] == err_byte;
  end

  logic        mon_done = 1'b0;
  logic        mon_write = 1'b0;
  logic [31:0] mon_addr = '0;
  logic [31:0] mon_wdata = '0;
  logic [31:0] mon_rdata = '0;
  logic        mon_err = 1'b0;

  always @(posedge clk) begin
    if (req.psel && !req.penable) begin
      if (!req.pwrite && req.paddr == A_LSR && wait_req != wait_used) begin
        wait_left <= 5;
        wait_used <= wait_used + 1;
      end else begin
        wait_left <= 0;
      end
    end else if (req.psel && req.penable && wait_left != 0) begin
      wait_left <= wait_left - 1;
    end
    if (req.psel && req.penable && rsp.pready) begin
      if (!req.pwrite && req.paddr == A_DATA && slv_dr) rx_rd <= rx_rd + 1;
      if (rsp.pslverr) err_used <= err_used + 1;
    end
    mon_done  <= !rst_i && req.psel && req.penable && rsp.pready;
    mon_write <= req.pwrite;
    mon_addr  <= req.paddr;
    mon_wdata <= req.pwdata;
    mon_rdata <= rsp.prdata;
    mon_err   <= rsp.pslverr;
  end

  // ---------------- checking ----------------
  int         errors = 0;
  int         checks = 0;
  xfer_t      exp_q[$];
  logic [7:0] tx_q[$];
  int         log_kind[$];
  bit         hs_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int budget);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within %0d cycles", name, budget);
  endtask

  // One cycle: feed tx stream, then score any transfer completed at the last edge.
  task automatic step();
    xfer_t e;
    @(negedge clk);
    if (hs_pending) tx_q.delete(0);
    tx_valid   = (tx_q.size() != 0);
    tx_data    = tx_valid ? tx_q[0] : 8'h00;
    hs_pending = tx_ready && tx_valid;
    if (mon_done) begin
      if (!mon_write && mon_addr == A_LSR) begin
        log_kind.push_back(0);
      end else begin
        log_kind.push_back(mon_write ? 1 : 2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got w=%0b addr %h wdata %h, required no transfer",
                   mon_write, mon_addr, mon_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_write", {31'd0, mon_write}, {31'd0, e.write});
          chk("xfer_addr", mon_addr, e.addr);
          chk("xfer_data", mon_write ? mon_wdata : {24'd0, mon_rdata[7:0]}, e.data);
          if (!mon_write && !mon_err) begin
            chk("rx_valid_after_rbr", {31'd0, rx_valid}, 32'd1);
            chk("rx_data_after_rbr", {24'd0, rx_data}, e.data);
          end
        end
      end
    end
  endtask

  task automatic wait_exp_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) timeout(name, budget);
  endtask

  task automatic wait_rx(input string name, input int budget);
    int n = 0;
    while (!rx_valid && n < budget) begin
      step();
      n++;
    end
    if (!rx_valid) timeout(name, budget);
  endtask

  task automatic push_init(input xfer_t tbl[6]);
    for (int i = 0; i < 6; i++) exp_q.push_back(tbl[i]);
  endtask

  // Six init writes back to back; init_done high from cycle 12.
  task automatic run_init_check();
    for (int c = 0; c <= 12; c++) begin
      step();
      chk("init_psel", {31'd0, req.psel}, 32'd1);
      if (c == 11) chk("init_done_c11", {31'd0, init_done}, 32'd0);
      if (c == 12) chk("init_done_c12", {31'd0, init_done}, 32'd1);
    end
    chk("init_xfers_left", exp_q.size(), 32'd0);
  endtask

  task automatic push_rx(input logic [7:0] b);
    xfer_t e;
    rx_bytes[rx_wr[5:0]] = b;
    rx_wr++;
    e.write = 1'b0; e.addr = A_DATA; e.data = {24'd0, b};
    exp_q.push_back(e);
  endtask

  task automatic push_tx(input logic [7:0] b, input bit expect_write);
    xfer_t e;
    tx_q.push_back(b);
    if (expect_write) begin
      e.write = 1'b1; e.addr = A_DATA; e.data = {24'd0, b};
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t   init_tbl[6];
    rx_vec_t rx_tbl[4];
    int      w, polls_a, polls_b, polls_c, stall, n;
    logic [31:0] held_addr;

    init_tbl = '{'{1'b1, 32'h0C, 32'h80}, '{1'b1, 32'h00, 32'h34},
                 '{1'b1, 32'h04, 32'h12}, '{1'b1, 32'h0C, 32'h03},
                 '{1'b1, 32'h08, 32'h07}, '{1'b1, 32'h04, 32'h00}};
    rx_tbl   = '{'{8'h00, 8'h00}, '{8'hFF, 8'hFF}, '{8'h3C, 8'h3C}, '{8'h81, 8'h81}};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_psel", {31'd0, req.psel}, 32'd0);
    chk("rst_penable", {31'd0, req.penable}, 32'd0);
    chk("rst_pwrite", {31'd0, req.pwrite}, 32'd0);
    chk("rst_paddr", req.paddr, 32'd0);
    chk("rst_pwdata", req.pwdata, 32'd0);
    chk("rst_outs", {27'd0, tx_ready, rx_valid, init_done, err, 1'b0}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rst_i = 1'b0;

    push_init(init_tbl);
    run_init_check();
    chk("err_after_init", {31'd0, err}, 32'd0);

    // 20 bytes: 16 back-to-back writes, one poll, then 4 more
    repeat (4) step();
    log_kind.delete();
    for (int i = 0; i < 20; i++) push_tx(8'(i), 1'b1);
    wait_exp_empty("tx20_done", 200);
    w = 0; polls_a = 0; polls_b = 0; polls_c = 0;
    foreach (log_kind[i]) begin
      if (log_kind[i] == 1) w++;
      else if (log_kind[i] == 0 && w >= 1 && w < 20) begin
        if (w < 16) polls_a++;
        else if (w == 16) polls_b++;
        else polls_c++;
      end
    end
    chk("tx20_writes", w, 32'd20);
    chk("tx20_polls_in_burst", polls_a, 32'd0);
    chk("tx20_polls_at_16", polls_b, 32'd1);
    chk("tx20_polls_in_tail", polls_c, 32'd0);

    // RX hold: second byte waits until the first is consumed
    push_rx(8'hA5);
    wait_rx("rx_a5", 40);
    chk("rx_a5_data", {24'd0, rx_data}, 32'hA5);
    push_rx(8'h5A);
    repeat (20) step();
    chk("rx_hold_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx_hold_data", {24'd0, rx_data}, 32'hA5);
    chk("rx_no_rbr_while_full", exp_q.size(), 32'd1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    wait_rx("rx_5a", 40);
    chk("rx_5a_data", {24'd0, rx_data}, 32'h5A);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("rx_5a_consumed", {31'd0, rx_valid}, 32'd0);

    // RX table
    for (int i = 0; i < 4; i++) begin
      push_rx(rx_tbl[i].rbr_in);
      wait_rx("rx_tbl_wait", 40);
      chk("rx_tbl_data", {24'd0, rx_data}, {24'd0, rx_tbl[i].exp_rx_data});
      repeat (3) step();
      chk("rx_tbl_hold", {31'd0, rx_valid}, 32'd1);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("rx_tbl_clear", {31'd0, rx_valid}, 32'd0);
    end
    chk("rx_queue_empty", exp_q.size(), 32'd0);

    // pslverr on THR write of 0x55: sticky err, no retry
    chk("err_before_slverr", {31'd0, err}, 32'd0);
    err_byte = 8'h55;
    err_req++;
    push_tx(8'h55, 1'b1);
    push_tx(8'h56, 1'b1);
    wait_exp_empty("slverr_tx", 60);
    chk("err_set", {31'd0, err}, 32'd1);
    repeat (10) step();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Five wait states on an LSR read
    wait_req++;
    n = 0;
    while (!(req.psel && req.penable && !rsp.pready && req.paddr == A_LSR) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) timeout("lsr_wait_start", 20);
    push_tx(8'h77, 1'b1);
    tx_valid  = 1'b1;
    tx_data   = 8'h77;
    held_addr = req.paddr;
    chk("stall_tx_ready", {31'd0, tx_ready}, 32'd0);
    stall = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp.pready) break;
      stall++;
      chk("stall_psel_penable", {30'd0, req.psel, req.penable}, 32'd3);
      chk("stall_paddr", req.paddr, held_addr);
      chk("stall_tx_ready", {31'd0, tx_ready}, 32'd0);
    end
    chk("stall_cycles", stall, 32'd5);
    wait_exp_empty("after_stall_tx", 40);

    // Reset during a THR ACCESS
    push_tx(8'h99, 1'b0);
    n = 0;
    while (!(req.psel && req.penable && req.pwrite && req.paddr == A_DATA) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) timeout("thr_access", 20);
    rst_i = 1'b1;
    step();
    chk("midrst_psel_penable", {30'd0, req.psel, req.penable}, 32'd0);
    chk("midrst_flags", {29'd0, init_done, err, rx_valid}, 32'd0);
    thre  = 1'b0;
    rst_i = 1'b0;
    push_init(init_tbl);
    run_init_check();

    // Credit was cleared by reset: no write until THRE is seen again
    push_tx(8'hAB, 1'b0);
    repeat (20) step();
    chk("no_credit_after_reset", tx_q.size(), 32'd1);
    thre = 1'b1;
    exp_q.push_back('{1'b1, A_DATA, 32'hAB});
    wait_exp_empty("tx_after_reset", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
